// File: rtl/calendar_alarm_core.sv
// ---------------------------------------------------------------------------
// calendar_alarm_core
//
// Full calendar time-keeper (second .. year) with leap-year handling, a
// validated load handshake, a 12/24-hour display view and NUM_ALARM
// independent sticky alarm channels. The calendar advances on the one-cycle
// clk1sec enable.
//
// Parameters
//   YEAR_BASE  calendar year represented by year==0 (leap-year rule only)
//   NUM_ALARM  number of alarm channels, 1..8
//   YEAR_MAX   last year offset before year wraps to 0, <=255
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   clk1sec     one-cycle 1 Hz advance enable
//   set_time    one-cycle load strobe
//   bin_time    {year,month,day,hour,minute,second}, 8 bits each, binary
//   mode_12h    1 = disp_hour shown in 12-hour form
//   alarm_en    per-channel alarm enable
//   alarm_time  per channel {hour[15:8],minute[7:0]}, channel 0 in LSBs
//   alarm_ack   per-channel clear pulse
//   year..second  current time, binary, registered
//   disp_hour   display hour, decoded from the registered hour
//   pm          1 when hour >= 12, decoded from the registered hour
//   alarm_hit   sticky per-channel alarm flags, registered
//   set_err     one-cycle pulse after a rejected load, registered
// ---------------------------------------------------------------------------
module calendar_alarm_core #(
  parameter int YEAR_BASE = 2000,
  parameter int NUM_ALARM = 2,
  parameter int YEAR_MAX  = 99
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk1sec,
  input  logic                   set_time,
  input  logic [47:0]            bin_time,
  input  logic                   mode_12h,
  input  logic [NUM_ALARM-1:0]   alarm_en,
  input  logic [16*NUM_ALARM-1:0] alarm_time,
  input  logic [NUM_ALARM-1:0]   alarm_ack,
  output logic [7:0]             year,
  output logic [7:0]             month,
  output logic [7:0]             day,
  output logic [7:0]             hour,
  output logic [7:0]             minute,
  output logic [7:0]             second,
  output logic [7:0]             disp_hour,
  output logic                   pm,
  output logic [NUM_ALARM-1:0]   alarm_hit,
  output logic                   set_err
);

  localparam logic [7:0] LP_YEAR_MAX = 8'(YEAR_MAX);

  // -------------------------------------------------------------------------
  // Calendar helpers
  // -------------------------------------------------------------------------
  function automatic logic is_leap(input logic [7:0] y);
    int full;
    full = YEAR_BASE + int'(y);
    return ((full % 4) == 0) && (((full % 100) != 0) || ((full % 400) == 0));
  endfunction

  // Returns 0 for an out-of-range month so that any day check fails.
  function automatic logic [7:0] days_in_month(input logic [7:0] m,
                                               input logic [7:0] y);
    logic [7:0] d;
    case (m)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: d = 8'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    d = 8'd30;
      8'd2:                                       d = is_leap(y) ? 8'd29 : 8'd28;
      default:                                    d = 8'd0;
    endcase
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]           r_year;
  logic [7:0]           r_month;
  logic [7:0]           r_day;
  logic [7:0]           r_hour;
  logic [7:0]           r_minute;
  logic [7:0]           r_second;
  logic [NUM_ALARM-1:0] r_alarm_hit;
  logic                 r_set_err;

  // -------------------------------------------------------------------------
  // Tick (increment) path: carry chain from second up to year
  // -------------------------------------------------------------------------
  logic [7:0] w_dim_cur;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hour_wrap;
  logic       w_day_wrap;
  logic       w_mon_wrap;
  logic [7:0] w_tick_year;
  logic [7:0] w_tick_month;
  logic [7:0] w_tick_day;
  logic [7:0] w_tick_hour;
  logic [7:0] w_tick_minute;
  logic [7:0] w_tick_second;

  assign w_dim_cur   = days_in_month(r_month, r_year);
  assign w_sec_wrap  = (r_second == 8'd59);
  assign w_min_wrap  = w_sec_wrap  && (r_minute == 8'd59);
  assign w_hour_wrap = w_min_wrap  && (r_hour == 8'd23);
  assign w_day_wrap  = w_hour_wrap && (r_day == w_dim_cur);
  assign w_mon_wrap  = w_day_wrap  && (r_month == 8'd12);

  assign w_tick_second = w_sec_wrap ? 8'd0 : r_second + 8'd1;
  assign w_tick_minute = !w_sec_wrap ? r_minute :
                         (w_min_wrap ? 8'd0 : r_minute + 8'd1);
  assign w_tick_hour   = !w_min_wrap ? r_hour :
                         (w_hour_wrap ? 8'd0 : r_hour + 8'd1);
  assign w_tick_day    = !w_hour_wrap ? r_day :
                         (w_day_wrap ? 8'd1 : r_day + 8'd1);
  assign w_tick_month  = !w_day_wrap ? r_month :
                         (w_mon_wrap ? 8'd1 : r_month + 8'd1);
  assign w_tick_year   = !w_mon_wrap ? r_year :
                         ((r_year == LP_YEAR_MAX) ? 8'd0 : r_year + 8'd1);

  // -------------------------------------------------------------------------
  // Load path: validate the requested time before accepting it
  // -------------------------------------------------------------------------
  logic [7:0] w_set_year;
  logic [7:0] w_set_month;
  logic [7:0] w_set_day;
  logic [7:0] w_set_hour;
  logic [7:0] w_set_minute;
  logic [7:0] w_set_second;
  logic [7:0] w_set_dim;
  logic       w_set_valid;

  assign w_set_year   = bin_time[47:40];
  assign w_set_month  = bin_time[39:32];
  assign w_set_day    = bin_time[31:24];
  assign w_set_hour   = bin_time[23:16];
  assign w_set_minute = bin_time[15:8];
  assign w_set_second = bin_time[7:0];

  // Month length comes from the requested year/month, not the current date.
  assign w_set_dim   = days_in_month(w_set_month, w_set_year);
  assign w_set_valid = (w_set_month >= 8'd1) && (w_set_month <= 8'd12) &&
                       (w_set_day >= 8'd1) && (w_set_day <= w_set_dim) &&
                       (w_set_hour <= 8'd23) && (w_set_minute <= 8'd59) &&
                       (w_set_second <= 8'd59) && (w_set_year <= LP_YEAR_MAX);

  // A load takes priority over a coincident tick; the tick is dropped.
  logic w_do_tick;
  assign w_do_tick = clk1sec && !set_time;

  // -------------------------------------------------------------------------
  // Alarm match: only a real tick landing on second 0 can fire a channel.
  // Out-of-range alarm times can never equal a legal tick hour/minute.
  // -------------------------------------------------------------------------
  logic [NUM_ALARM-1:0] w_fire;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < NUM_ALARM; i++) begin
      w_fire[i] = w_do_tick && w_sec_wrap && alarm_en[i] &&
                  (alarm_time[16*i+8 +: 8] == w_tick_hour) &&
                  (alarm_time[16*i   +: 8] == w_tick_minute);
    end
  end

  // -------------------------------------------------------------------------
  // Sequential update
  // -------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_year      <= 8'd0;
      r_month     <= 8'd1;
      r_day       <= 8'd1;
      r_hour      <= 8'd0;
      r_minute    <= 8'd0;
      r_second    <= 8'd0;
      r_alarm_hit <= '0;
      r_set_err   <= 1'b0;
    end else begin
      r_set_err <= set_time && !w_set_valid;

      if (set_time) begin
        if (w_set_valid) begin
          r_year   <= w_set_year;
          r_month  <= w_set_month;
          r_day    <= w_set_day;
          r_hour   <= w_set_hour;
          r_minute <= w_set_minute;
          r_second <= w_set_second;
        end
      end else if (clk1sec) begin
        r_year   <= w_tick_year;
        r_month  <= w_tick_month;
        r_day    <= w_tick_day;
        r_hour   <= w_tick_hour;
        r_minute <= w_tick_minute;
        r_second <= w_tick_second;
      end

      // A fresh fire beats a same-cycle ack; disabling a channel clears it.
      r_alarm_hit <= w_fire | (r_alarm_hit & ~alarm_ack & alarm_en);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign year      = r_year;
  assign month     = r_month;
  assign day       = r_day;
  assign hour      = r_hour;
  assign minute    = r_minute;
  assign second    = r_second;
  assign alarm_hit = r_alarm_hit;
  assign set_err   = r_set_err;

  assign pm = (r_hour >= 8'd12);

  // 12-hour view: 0 -> 12, 1..12 unchanged, 13..23 -> hour-12.
  always_comb begin
    disp_hour = r_hour;
    if (mode_12h) begin
      if (r_hour == 8'd0) begin
        disp_hour = 8'd12;
      end else if (r_hour > 8'd12) begin
        disp_hour = r_hour - 8'd12;
      end
    end
  end

endmodule

// File: tb/tb_calendar_alarm_core.sv
// ---------------------------------------------------------------------------
// tb_calendar_alarm_core
//
// Self-checking bench for calendar_alarm_core. A behavioural model keeps the
// time as a date plus seconds-of-day and advances it with plain arithmetic;
// every output is compared against it after each clock, and directed
// constant checks pin the key calendar, load and alarm cases.
// ---------------------------------------------------------------------------
module tb_calendar_alarm_core;

  localparam int YB = 2000;
  localparam int NA = 2;
  localparam int YM = 99;

  logic              clk;
  logic              rst_n;
  logic              clk1sec;
  logic              set_time;
  logic [47:0]       bin_time;
  logic              mode_12h;
  logic [NA-1:0]     alarm_en;
  logic [16*NA-1:0]  alarm_time;
  logic [NA-1:0]     alarm_ack;
  logic [7:0]        year;
  logic [7:0]        month;
  logic [7:0]        day;
  logic [7:0]        hour;
  logic [7:0]        minute;
  logic [7:0]        second;
  logic [7:0]        disp_hour;
  logic              pm;
  logic [NA-1:0]     alarm_hit;
  logic              set_err;

  int checks   = 0;
  int failures = 0;

  // Model state
  int            m_year;
  int            m_month;
  int            m_day;
  int            m_sod;   // seconds of day, 0..86399
  logic [NA-1:0] m_hit;
  logic          m_err;

  calendar_alarm_core #(
    .YEAR_BASE (YB),
    .NUM_ALARM (NA),
    .YEAR_MAX  (YM)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .clk1sec    (clk1sec),
    .set_time   (set_time),
    .bin_time   (bin_time),
    .mode_12h   (mode_12h),
    .alarm_en   (alarm_en),
    .alarm_time (alarm_time),
    .alarm_ack  (alarm_ack),
    .year       (year),
    .month      (month),
    .day        (day),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .disp_hour  (disp_hour),
    .pm         (pm),
    .alarm_hit  (alarm_hit),
    .set_err    (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic int model_dim(input int m, input int y);
    int  full;
    bit  leap;
    full = YB + y;
    leap = ((full % 4) == 0) && (((full % 100) != 0) || ((full % 400) == 0));
    if (m < 1 || m > 12) return 0;
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic bit model_valid(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= model_dim(mo, y)) &&
           (h <= 23) && (mi <= 59) && (s <= 59) && (y <= YM);
  endfunction

  function automatic int model_disp(input int h, input logic m12);
    if (!m12) return h;
    if (h % 12 == 0) return 12;
    return h % 12;
  endfunction

  task automatic model_reset();
    m_year  = 0;
    m_month = 1;
    m_day   = 1;
    m_sod   = 0;
    m_hit   = '0;
    m_err   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("year",      32'(year),      32'(m_year));
    check("month",     32'(month),     32'(m_month));
    check("day",       32'(day),       32'(m_day));
    check("hour",      32'(hour),      32'(m_sod / 3600));
    check("minute",    32'(minute),    32'((m_sod / 60) % 60));
    check("second",    32'(second),    32'(m_sod % 60));
    check("disp_hour", 32'(disp_hour), 32'(model_disp(m_sod / 3600, mode_12h)));
    check("pm",        32'(pm),        32'((m_sod / 3600) >= 12));
    check("alarm_hit", 32'(alarm_hit), 32'(m_hit));
    check("set_err",   32'(set_err),   32'(m_err));
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic step();
    int            n_y, n_mo, n_d, n_sod;
    int            sy, smo, sd, sh, smi, ss, ah, am;
    logic [NA-1:0] n_hit;
    logic          n_err;
    bit            ticked;
    bit            fire;
    n_y = m_year; n_mo = m_month; n_d = m_day; n_sod = m_sod;
    ticked = 0;
    n_err  = 1'b0;
    sy  = int'(bin_time[47:40]);
    smo = int'(bin_time[39:32]);
    sd  = int'(bin_time[31:24]);
    sh  = int'(bin_time[23:16]);
    smi = int'(bin_time[15:8]);
    ss  = int'(bin_time[7:0]);
    if (set_time) begin
      if (model_valid(sy, smo, sd, sh, smi, ss)) begin
        n_y = sy; n_mo = smo; n_d = sd; n_sod = sh * 3600 + smi * 60 + ss;
      end else begin
        n_err = 1'b1;
      end
    end else if (clk1sec) begin
      ticked = 1;
      n_sod  = m_sod + 1;
      if (n_sod == 86400) begin
        n_sod = 0;
        n_d   = n_d + 1;
        if (n_d > model_dim(n_mo, n_y)) begin
          n_d  = 1;
          n_mo = n_mo + 1;
          if (n_mo > 12) begin
            n_mo = 1;
            n_y  = (n_y == YM) ? 0 : n_y + 1;
          end
        end
      end
    end
    for (int i = 0; i < NA; i++) begin
      ah   = int'(alarm_time[16*i+8 +: 8]);
      am   = int'(alarm_time[16*i +: 8]);
      fire = ticked && (n_sod % 60 == 0) && alarm_en[i] &&
             (ah == n_sod / 3600) && (am == (n_sod / 60) % 60);
      if (fire)                             n_hit[i] = 1'b1;
      else if (alarm_ack[i] || !alarm_en[i]) n_hit[i] = 1'b0;
      else                                  n_hit[i] = m_hit[i];
    end
    @(posedge clk);
    #1;
    m_year = n_y; m_month = n_mo; m_day = n_d; m_sod = n_sod;
    m_hit = n_hit; m_err = n_err;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      clk1sec = 1'b1;
      step();
      clk1sec = 1'b0;
    end
  endtask

  task automatic load(input int y, input int mo, input int d, input int h,
                      input int mi, input int s, input bit with_tick);
    bin_time = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    set_time = 1'b1;
    clk1sec  = with_tick;
    step();
    set_time = 1'b0;
    clk1sec  = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int act, ch, nm, ry, rmo, burst;
    rst_n      = 1'b0;
    clk1sec    = 1'b0;
    set_time   = 1'b0;
    bin_time   = '0;
    mode_12h   = 1'b0;
    alarm_en   = '0;
    alarm_time = '0;
    alarm_ack  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // 61 ticks from reset
    tick_n(61);
    check("tp1_second", 32'(second), 32'd1);
    check("tp1_minute", 32'(minute), 32'd1);
    check("tp1_hour",   32'(hour),   32'd0);

    // Leap February 2024, then common February 2023
    load(24, 2, 28, 23, 59, 59, 0);
    tick_n(1);
    check("leap_day",   32'(day),    32'd29);
    check("leap_month", 32'(month),  32'd2);
    check("leap_hour",  32'(hour),   32'd0);
    load(23, 2, 28, 23, 59, 59, 0);
    tick_n(1);
    check("nonleap_month", 32'(month), 32'd3);
    check("nonleap_day",   32'(day),   32'd1);

    // Year wrap at YEAR_MAX
    load(YM, 12, 31, 23, 59, 59, 0);
    tick_n(1);
    check("wrap_year",  32'(year),  32'd0);
    check("wrap_month", 32'(month), 32'd1);
    check("wrap_day",   32'(day),   32'd1);

    // Invalid loads: month 13, then 29 Feb 2023
    load(5, 13, 1, 0, 0, 0, 0);
    check("bad_month_err",   32'(set_err), 32'd1);
    check("bad_month_keep",  32'(month),   32'd1);
    check("bad_month_year",  32'(year),    32'd0);
    idle(1);
    check("err_one_cycle",   32'(set_err), 32'd0);
    load(23, 2, 29, 0, 0, 0, 0);
    check("bad_feb_err",     32'(set_err), 32'd1);
    check("bad_feb_year",    32'(year),    32'd0);
    idle(1);

    // Set wins over a coincident tick
    load(10, 5, 5, 6, 59, 59, 1);
    check("set_wins_hour",   32'(hour),   32'd6);
    check("set_wins_minute", 32'(minute), 32'd59);
    check("set_wins_second", 32'(second), 32'd59);

    // Alarms: ch0 07:00 enabled, ch1 07:00 disabled
    alarm_time = {16'h0700, 16'h0700};
    alarm_en   = 2'b01;
    load(10, 5, 5, 6, 59, 59, 0);
    tick_n(1);
    check("alarm_fire", 32'(alarm_hit), 32'd1);
    load(10, 5, 5, 6, 59, 59, 0);
    check("alarm_load_hold", 32'(alarm_hit), 32'd1);
    clk1sec   = 1'b1;
    alarm_ack = 2'b01;
    step();
    clk1sec   = 1'b0;
    check("alarm_fire_beats_ack", 32'(alarm_hit), 32'd1);
    step();
    alarm_ack = 2'b00;
    check("alarm_ack_clear", 32'(alarm_hit), 32'd0);

    // 12/24-hour view
    mode_12h = 1'b1;
    load(1, 1, 1, 0, 0, 0, 0);
    check("h0_disp", 32'(disp_hour), 32'd12);
    check("h0_pm",   32'(pm),        32'd0);
    load(1, 1, 1, 12, 0, 0, 0);
    check("h12_disp", 32'(disp_hour), 32'd12);
    check("h12_pm",   32'(pm),        32'd1);
    load(1, 1, 1, 23, 0, 0, 0);
    check("h23_disp", 32'(disp_hour), 32'd11);
    check("h23_pm",   32'(pm),        32'd1);
    mode_12h = 1'b0;
    #1;
    check("h23_disp24", 32'(disp_hour), 32'd23);

    // Asynchronous reset mid-operation, released away from a clock edge
    alarm_en = 2'b11;
    alarm_time = {16'h1730, 16'h1730};
    load(7, 8, 9, 17, 29, 59, 0);
    tick_n(1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    alarm_en = '0;
    tick_n(1);
    check("post_rst_second", 32'(second), 32'd1);
    check("post_rst_day",    32'(day),    32'd1);

    // Randomized operation against the model
    for (int it = 0; it < 400; it++) begin
      act = $urandom_range(0, 9);
      case (act)
        0: load($urandom_range(0, 110), $urandom_range(0, 13),
                $urandom_range(0, 32), $urandom_range(0, 24),
                $urandom_range(0, 60), $urandom_range(0, 60),
                1'($urandom_range(0, 1)));
        1: begin
          nm = (m_sod / 60 + 1) % 1440;
          ch = $urandom_range(0, NA - 1);
          alarm_time[16*ch +: 16] = {8'(nm / 60), 8'(nm % 60)};
          alarm_en[ch] = 1'b1;
          load(m_year, m_month, m_day, m_sod / 3600, (m_sod / 60) % 60, 59, 0);
          tick_n(1);
        end
        2: begin
          alarm_en  = NA'($urandom);
          alarm_ack = NA'($urandom);
          if ($urandom_range(0, 3) == 0) alarm_time = (16*NA)'($urandom);
          step();
          alarm_ack = '0;
        end
        3: mode_12h = 1'($urandom_range(0, 1));
        4: begin
          ry  = $urandom_range(0, YM);
          rmo = $urandom_range(1, 12);
          load(ry, rmo, model_dim(rmo, ry), 23, 59, 58, 0);
          tick_n(3);
        end
        default: begin
          burst = $urandom_range(1, 80);
          for (int b = 0; b < burst; b++) begin
            clk1sec   = 1'($urandom_range(0, 1));
            alarm_ack = ($urandom_range(0, 15) == 0) ? NA'($urandom) : '0;
            step();
          end
          clk1sec   = 1'b0;
          alarm_ack = '0;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calendar_alarm_core.md
Name: calendar_alarm_core

Overview:
Parametrised successor to the existing time-keeping core: a full calendar counter (second through year) with leap-year handling, a validated set handshake, a 12/24-hour display view, and NUM_ALARM independent alarm channels. It is advanced by the shared one-cycle clk1sec enable and feeds the mode/display blocks in the digital clock top. All outputs are registered except disp_hour/pm, which are decoded from the registered hour.

Parameters:
YEAR_BASE, 2000, calendar year represented by year==0; used only for the leap-year rule.
NUM_ALARM, 2, number of alarm channels, 1..8.
YEAR_MAX, 99, last year offset before the year wraps to 0; must be <=255.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
clk1sec  in  1  one-cycle 1 Hz enable
set_time  in  1  one-cycle load strobe
bin_time  in  48  {year,month,day,hour,minute,second}, 8 bits each, binary
mode_12h  in  1  1 = disp_hour is in 12-hour form
alarm_en  in  NUM_ALARM  per-channel enable
alarm_time  in  16*NUM_ALARM  per channel {hour[15:8],minute[7:0]}; channel 0 in the LSBs
alarm_ack  in  NUM_ALARM  per-channel clear pulse
year,month,day,hour,minute,second  out  8 each  current time, binary
disp_hour  out  8  display hour
pm  out  1  1 when hour>=12
alarm_hit  out  NUM_ALARM  sticky alarm flags
set_err  out  1  one-cycle pulse when a set request is rejected

Behaviour:
- Reset (rst=0, async): year=0, month=1, day=1, hour=0, minute=0, second=0, alarm_hit=0, set_err=0.
- Tick: on a clk1sec=1 cycle the fields update on that clock edge; the new value is visible 1 cycle after the tick.
- Carry chain:
  - second 59->0 carries to minute.
  - minute 59->0 carries to hour.
  - hour 23->0 carries to day.
  - day==dim(month,year)->1 carries to month.
  - month 12->1 carries to year.
  - year YEAR_MAX->0.
- dim (days in month) = 31/30 per month. February = 29 if leap, else 28.
- Leap rule: Y=YEAR_BASE+year is leap if Y%4==0 and (Y%100!=0 or Y%400==0).
- Set validation: valid iff month 1..12, day 1..dim(month,year_in), hour<=23, minute<=59, second<=59, year<=YEAR_MAX. dim is computed from the bin_time year and month.
- set_time=1 and valid: load all six fields at that edge.
- set_time=1 and invalid: no field changes; set_err=1 for exactly the next cycle.
- set_time and clk1sec in the same cycle: set wins, and that tick is discarded (loaded value is not incremented).
- Alarms are evaluated only on tick updates, never on a load. Channel i fires when a tick produces second==0, the new hour:minute equals alarm_time[i], and alarm_en[i]=1. Firing sets alarm_hit[i]=1 in the same update.
- alarm_hit[i] stays set until alarm_ack[i]=1 or alarm_en[i]=0, either of which clears it next edge.
- alarm_ack[i] and a new fire in the same cycle: the fire wins, hit stays 1.
- Alarm channels are fully independent; several may fire on one tick.
- Out-of-range alarm_time values never match and are not an error.
- disp_hour, mode_12h=0: disp_hour=hour.
- disp_hour, mode_12h=1: hour 0 gives 12; 1..12 unchanged; 13..23 gives hour-12.
- pm=(hour>=12) regardless of mode_12h.
- Reset asserted mid-operation returns everything to the reset values immediately. The first tick after release increments from 00:00:00 on day 1, month 1.

Test Plan:
- Reset then 61 ticks -> second=1, minute=1, hour=0. Check alarm_hit=0 and set_err=0 throughout.
- Load year=24, month=2, day=28, 23:59:59 (Y=2024), then tick -> day=29, month=2, 00:00:00. Load the same time with year=23, then tick -> month=3, day=1.
- Load 12/31 23:59:59 with year=YEAR_MAX (99), then tick -> year=0, month=1, day=1, 00:00:00. Load month=13 -> fields unchanged, set_err high for exactly 1 cycle. Load year=23, day=29, month=2 -> rejected.
- Load 06:59:59 and assert clk1sec together with set_time -> time reads 06:59:59, not 07:00:00.
- Alarm ch0=07:00 enabled, ch1=07:00 disabled; load 06:59:59, then tick -> alarm_hit=01. ack ch0 on the same cycle as a re-fire -> stays 1. ack alone -> 0.
- mode_12h=1: hour 0 -> disp_hour=12, pm=0. hour 12 -> 12, pm=1. hour 23 -> 11, pm=1. mode_12h=0 with hour 23 -> disp_hour=23.
